// File: rtl/note_sequencer.sv
// Note sequencer: buffers note commands in a small FIFO and plays them back-to-back
// with exact tick-based durations and a fixed silent gap, driving freq_x100/gate.
module note_sequencer #(
  parameter int TICK_DIV   = 50000,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_TICKS  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    cmd_note,
  input  logic [2:0]                    cmd_octave,
  input  logic [15:0]                   cmd_dur,
  input  logic                          stop,
  output logic [19:0]                   freq_x100,
  output logic                          gate,
  output logic                          busy,
  output logic                          note_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // state | meaning
  // IDLE  | waiting for a queued command; pops the head when one is present
  // LOAD  | head registered; frequency computed, counters cleared
  // PLAY  | note sounding (or rest silent) for dur ticks
  // GAP   | articulation silence for GAP_TICKS ticks
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PRESC_END = PW'(TICK_DIV - 1);
  localparam logic [15:0]   GAP_LAST  = 16'(GAP_TICKS - 1);

  state_t state, state_nxt;

  logic [22:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  logic [3:0]    cur_note;
  logic [2:0]    cur_oct;
  logic [15:0]   cur_dur;
  logic          is_rest;
  logic [19:0]   freq_calc;

  logic [PW-1:0] presc;
  logic [15:0]   tick;
  logic          presc_last;
  logic          cnt_clr;

  logic [19:0]   freq_nxt;
  logic          gate_nxt;
  logic          done_nxt;

  function automatic logic [14:0] base_freq(input logic [3:0] n);
    case (n)
      4'd0:    base_freq = 15'd13081;
      4'd1:    base_freq = 15'd13859;
      4'd2:    base_freq = 15'd14683;
      4'd3:    base_freq = 15'd15556;
      4'd4:    base_freq = 15'd16481;
      4'd5:    base_freq = 15'd17461;
      4'd6:    base_freq = 15'd18500;
      4'd7:    base_freq = 15'd19600;
      4'd8:    base_freq = 15'd20765;
      4'd9:    base_freq = 15'd22000;
      4'd10:   base_freq = 15'd23308;
      4'd11:   base_freq = 15'd24694;
      default: base_freq = 15'd0;
    endcase
  endfunction

  assign cmd_ready  = (fifo_count < DEPTH_C) && !stop;
  assign push       = cmd_valid && cmd_ready;
  assign busy       = (state != IDLE) || (fifo_count != '0);
  assign is_rest    = cur_note[3] & cur_note[2];
  assign freq_calc  = {5'd0, base_freq(cur_note)} << cur_oct;
  assign presc_last = (presc == PRESC_END);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_note, cmd_octave, cmd_dur};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (stop) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Octave saturates at load so the shifter only ever sees 0..4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_note <= '0;
      cur_oct  <= '0;
      cur_dur  <= '0;
    end else if (pop) begin
      cur_note <= mem[rd_ptr][22:19];
      cur_oct  <= (mem[rd_ptr][18:16] > 3'd4) ? 3'd4 : mem[rd_ptr][18:16];
      cur_dur  <= mem[rd_ptr][15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      tick  <= '0;
    end else if (cnt_clr) begin
      presc <= '0;
      tick  <= '0;
    end else if (state == PLAY || state == GAP) begin
      if (presc_last) begin
        presc <= '0;
        tick  <= tick + 16'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      freq_x100 <= '0;
      gate      <= 1'b0;
      note_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      freq_x100 <= freq_nxt;
      gate      <= gate_nxt;
      note_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cnt_clr   = 1'b0;
    freq_nxt  = freq_x100;
    gate_nxt  = gate;
    done_nxt  = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
      freq_nxt  = '0;
      gate_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_count != '0) begin
            pop       = 1'b1;
            state_nxt = LOAD;
          end
        end
        LOAD: begin
          cnt_clr = 1'b1;
          if (cur_dur == 16'd0) begin
            done_nxt  = 1'b1;
            state_nxt = GAP;
          end else begin
            state_nxt = PLAY;
            gate_nxt  = !is_rest;
            freq_nxt  = is_rest ? 20'd0 : freq_calc;
          end
        end
        PLAY: begin
          if (presc_last && tick == cur_dur - 16'd1) begin
            cnt_clr   = 1'b1;
            done_nxt  = 1'b1;
            gate_nxt  = 1'b0;
            freq_nxt  = '0;
            state_nxt = GAP;
          end
        end
        GAP: begin
          if (GAP_TICKS == 0) begin
            state_nxt = IDLE;
          end else if (presc_last && tick == GAP_LAST) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4, GAP_TICKS=2, FIFO_DEPTH=4.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_note = '0;
  logic [2:0]  cmd_octave = '0;
  logic [15:0] cmd_dur = '0;
  logic        stop = 1'b0;
  logic [19:0] freq_x100;
  logic        gate;
  logic        busy;
  logic        note_done;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  note_sequencer #(.TICK_DIV(4), .FIFO_DEPTH(4), .GAP_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_note(cmd_note), .cmd_octave(cmd_octave), .cmd_dur(cmd_dur), .stop(stop),
    .freq_x100(freq_x100), .gate(gate), .busy(busy), .note_done(note_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // passive monitor, sampled on the falling edge
  int cyc = 0;
  int done_cnt = 0;
  int run = 0;
  int zero_viol = 0;
  int rdy_viol = 0;
  int full_seen = 0;
  logic gate_q = 1'b0;
  int freq_log[$];
  int len_log[$];
  int done_log[$];

  always @(negedge clk) begin
    cyc++;
    if (note_done) begin
      done_cnt++;
      done_log.push_back(cyc);
    end
    if (!gate && freq_x100 != 20'd0) zero_viol++;
    if (fifo_count == 3'd4) begin
      full_seen++;
      if (cmd_ready) rdy_viol++;
    end
    if (gate) begin
      if (!gate_q) freq_log.push_back(int'(freq_x100));
      run++;
    end else if (gate_q) begin
      len_log.push_back(run);
      run = 0;
    end
    gate_q = gate;
  end

  task automatic clr_mon();
    done_cnt = 0;
    run = 0;
    freq_log.delete();
    len_log.delete();
    done_log.delete();
  endtask

  // called just after a rising edge; returns just after the accepting edge
  task automatic push_cmd(input logic [3:0] n, input logic [2:0] o, input logic [15:0] d);
    logic rdy;
    cmd_note = n; cmd_octave = o; cmd_dur = d; cmd_valid = 1'b1;
    @(negedge clk);
    rdy = cmd_ready;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("push_ready", {31'd0, rdy}, 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_gate(input string tag, input int limit);
    int n = 0;
    while (!gate && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, gate}, 32'd1);
  endtask

  int exp_b2b[8] = '{13081, 27718, 58732, 15556, 32962, 69844, 18500, 39200};

  initial begin
    int hi;
    int gb;
    int accepted;
    logic rdy;

    // reset
    #22 rst_n = 1'b1;
    @(negedge clk);
    check("rst_gate", {31'd0, gate}, 32'd0);
    check("rst_freq", {12'd0, freq_x100}, 32'd0);
    check("rst_done", {31'd0, note_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // basic note with exact latency and gap
    clr_mon();
    push_cmd(4'd9, 3'd0, 16'd3);
    @(negedge clk);
    check("basic_cnt1", {29'd0, fifo_count}, 32'd1);
    check("basic_gate_t0", {31'd0, gate}, 32'd0);
    @(negedge clk);
    check("basic_cnt0", {29'd0, fifo_count}, 32'd0);
    check("basic_gate_load", {31'd0, gate}, 32'd0);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gate && freq_x100 == 20'd22000) hi++;
    end
    check("basic_hi", hi, 12);
    @(negedge clk);
    check("basic_gate_off", {31'd0, gate}, 32'd0);
    check("basic_done", {31'd0, note_done}, 32'd1);
    gb = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (busy && !gate && !note_done) gb++;
    end
    check("basic_gap", gb, 7);
    @(negedge clk);
    check("basic_idle", {31'd0, busy}, 32'd0);
    check("basic_ndone", done_cnt, 1);
    @(posedge clk); #1;

    // width, octave saturation and a rest
    clr_mon();
    push_cmd(4'd11, 3'd4, 16'd1);
    push_cmd(4'd11, 3'd6, 16'd1);
    push_cmd(4'd13, 3'd2, 16'd2);
    wait_idle("sat_idle", 200);
    check("sat_nnotes", freq_log.size(), 2);
    if (freq_log.size() == 2) begin
      check("sat_f0", freq_log[0], 395104);
      check("sat_f1", freq_log[1], 395104);
      check("sat_l0", len_log[0], 4);
      check("sat_l1", len_log[1], 4);
    end
    check("sat_ndone", done_cnt, 3);
    if (done_log.size() == 3) begin
      check("sat_sp1", done_log[1] - done_log[0], 14);
      check("rest_span", done_log[2] - done_log[1], 18);
    end

    // back-to-back with backpressure
    clr_mon();
    full_seen = 0;
    rdy_viol = 0;
    accepted = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int n = 0;
      cmd_note = 4'(i);
      cmd_octave = 3'(i % 3);
      cmd_dur = 16'd1;
      rdy = 1'b0;
      while (!rdy && n < 200) begin
        @(negedge clk);
        rdy = cmd_ready;
        @(posedge clk); #1;
        n++;
      end
      if (rdy) accepted++;
    end
    cmd_valid = 1'b0;
    check("b2b_accepted", accepted, 8);
    wait_idle("b2b_idle", 400);
    check("b2b_full_seen", {31'd0, full_seen > 0}, 32'd1);
    check("b2b_rdy_viol", rdy_viol, 0);
    check("b2b_ndone", done_cnt, 8);
    check("b2b_nnotes", freq_log.size(), 8);
    if (freq_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("b2b_f%0d", i), freq_log[i], exp_b2b[i]);
        check($sformatf("b2b_l%0d", i), len_log[i], 4);
      end
    end

    // zero duration
    clr_mon();
    push_cmd(4'd0, 3'd0, 16'd0);
    push_cmd(4'd2, 3'd1, 16'd1);
    wait_idle("zero_idle", 200);
    check("zero_nnotes", freq_log.size(), 1);
    if (freq_log.size() == 1) check("zero_f", freq_log[0], 29366);
    check("zero_ndone", done_cnt, 2);
    if (done_log.size() == 2) check("zero_span", done_log[1] - done_log[0], 14);

    // stop mid-PLAY with three entries queued
    clr_mon();
    for (int i = 0; i < 4; i++) push_cmd(4'd5, 3'd1, 16'd4);
    wait_gate("stop_gate_on", 50);
    @(negedge clk);
    @(negedge clk);
    check("stop_queued", {29'd0, fifo_count}, 32'd3);
    cmd_note = 4'd1; cmd_octave = 3'd0; cmd_dur = 16'd1;
    cmd_valid = 1'b1;
    stop = 1'b1;
    #1 check("stop_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    stop = 1'b0;
    cmd_valid = 1'b0;
    check("stop_gate", {31'd0, gate}, 32'd0);
    check("stop_freq", {12'd0, freq_x100}, 32'd0);
    check("stop_count", {29'd0, fifo_count}, 32'd0);
    check("stop_done", {31'd0, note_done}, 32'd0);
    check("stop_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 20; i++) @(negedge clk);
    check("stop_quiet", {31'd0, busy | gate}, 32'd0);
    check("stop_ndone", done_cnt, 0);
    @(posedge clk); #1;

    // asynchronous reset mid-note
    push_cmd(4'd4, 3'd3, 16'd4);
    push_cmd(4'd7, 3'd0, 16'd2);
    wait_gate("rst_gate_on", 50);
    check("rst_mid_f", {12'd0, freq_x100}, 32'd131848);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_gate", {31'd0, gate}, 32'd0);
    check("rst_async_freq", {12'd0, freq_x100}, 32'd0);
    check("rst_async_count", {29'd0, fifo_count}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_busy", {31'd0, busy}, 32'd0);
    check("rst_rel_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("rst_rel_quiet", {31'd0, gate}, 32'd0);

    check("freq_zero_when_off", zero_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Plays queued notes through the note-frequency datapath. It accepts note commands (note index, octave, duration) over a valid/ready interface and buffers them in a small FIFO. It then plays them back-to-back with exact millisecond durations and a fixed articulation gap. It drives `freq_x100` and `gate` to the tone generator and sits between the processor's command port and the audio output stage.

## Interface

**Parameters**
- `TICK_DIV`, default 50000: clock cycles per duration tick (1 ms at 50 MHz).
- `FIFO_DEPTH`, default 4: command FIFO entries; must be a power of two, ≥ 2.
- `GAP_TICKS`, default 2: silent ticks after every note or rest; 0 means no gap.

**Ports**
- `clk`, input, 1: single clock; all state on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: FIFO can accept a command.
- `cmd_note`, input, 4: 0..11 = C..B; 12..15 = rest.
- `cmd_octave`, input, 3: frequency multiplier is 2^octave; 0 = octave 3, 4 = octave 7; values 5..7 saturate to 4.
- `cmd_dur`, input, 16: duration in ticks.
- `stop`, input, 1: flush the FIFO and abort playback.
- `freq_x100`, output, 20: current frequency ×100; 0 when `gate` = 0.
- `gate`, output, 1: tone on.
- `busy`, output, 1: state ≠ IDLE or FIFO not empty.
- `note_done`, output, 1: one-cycle pulse when a note's or rest's duration completes.
- `fifo_count`, output, clog2(FIFO_DEPTH)+1 bits: number of queued entries.

## Operation
- **Base table** (×100, octave 3): 13081, 13859, 14683, 15556, 16481, 17461, 18500, 19600, 20765, 22000, 23308, 24694.
- **Frequency:** `freq_x100 = table[note] << min(octave,4)`. Maximum is 24694·16 = 395104, which fits in 20 bits. No division and no rounding.
- **FIFO push:** occurs when `cmd_valid && cmd_ready`. `cmd_ready = (fifo_count < FIFO_DEPTH) && !stop`.
- **FIFO pop:** occurs only on the IDLE→LOAD transition.
- **Push and pop in the same cycle:** both occur; `fifo_count` is unchanged.
- **State machine:**
  - IDLE: if the FIFO is not empty, pop the head and go to LOAD.
  - LOAD: register note, octave and dur; compute the frequency; clear the prescaler and tick counter. If dur = 0, pulse `note_done` and go to GAP. Otherwise go to PLAY.
  - PLAY: for a note, `gate` = 1 and `freq_x100` = computed value; for a rest, `gate` = 0 and `freq_x100` = 0. The prescaler counts 0..TICK_DIV-1, and each wrap increments the tick counter. When the tick counter reaches dur, pulse `note_done` and go to GAP. PLAY lasts exactly dur·TICK_DIV cycles.
  - GAP: `gate` = 0 and `freq_x100` = 0 for GAP_TICKS·TICK_DIV cycles, then go to IDLE. If GAP_TICKS = 0, go to IDLE after 1 cycle.
- **stop:** has priority over everything. On the next edge the FIFO is emptied, the state becomes IDLE, and `gate` and `freq_x100` become 0. No `note_done` pulse is issued for the aborted note, and no push is accepted in that cycle.
- **Reset values:**
  - state IDLE, FIFO empty, `fifo_count` = 0;
  - `gate` = 0, `freq_x100` = 0, `note_done` = 0, `busy` = 0;
  - `cmd_ready` = 1 once `rst_n` is high.
- **Reset mid-note:** `gate` drops asynchronously and all queued commands are lost.

## Timing
- All outputs are registered except `cmd_ready` and `busy`, which are combinational from registered state and `stop`.
- **Latency:** a command accepted at edge t into an empty FIFO with state IDLE gives IDLE→LOAD at edge t+1 and PLAY at edge t+2. `gate` and `freq_x100` are valid from edge t+2.
- `note_done` is high for the single cycle following the edge on which PLAY ends; `gate` is already 0 in that cycle.
- **Note spacing:** from one PLAY exit to the next PLAY entry takes GAP_TICKS·TICK_DIV + 2 cycles (GAP, then IDLE, then LOAD).
- **Throughput:** one command per cycle into the FIFO until it is full.

## Test plan
All scenarios use TICK_DIV = 4, GAP_TICKS = 2, FIFO_DEPTH = 4.

- **Basic note:** push {note 9, oct 0, dur 3}. Expect `gate` high for exactly 12 cycles starting 2 edges after acceptance, with `freq_x100` = 22000. Then one `note_done` pulse, 8 cycles of `gate` = 0, and `busy` low afterwards.
- **Width and saturation:** push {11, 4, 1} then {11, 6, 1}. Expect 395104 for both notes. Push a rest {13, 2, 2}: expect `gate` = 0 for 8 cycles and `note_done` pulsed.
- **Back-to-back and backpressure:** hold `cmd_valid` with 8 distinct commands. Expect `cmd_ready` low whenever `fifo_count` = 4, all 8 notes played in order, and exactly 8 `note_done` pulses.
- **Zero duration:** push {0, 0, 0} followed by {2, 1, 1}. Expect no `gate` for the first command, a `note_done` pulse, then `freq_x100` = 29366.
- **stop:** assert `stop` mid-PLAY with 3 entries queued and `cmd_valid` high. Expect `gate` = 0 next cycle, `fifo_count` = 0, no `note_done`, and no push accepted.
- **Reset mid-note:** pull `rst_n` low mid-PLAY. Expect `gate` and `freq_x100` to become 0 immediately; after release, `busy` = 0 and `cmd_ready` = 1.
